mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single read port of the node memory (qValue table at 0x1C8, HCM table at 0x648, etc.) between up to NUM_REQ search/compute engines such as the best-Q-value finder. Grants one requester at a time in round-robin order, with a lock so an engine can hold the port for a sequential table scan. Drives the memory address/read strobe and returns read data to the owning engine with a one-hot valid tag.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 16, memory byte address width
- DATA_W, 16, memory word width
- RD_LAT, 1, memory read latency in cycles (1..4)
- MAX_HOLD, 256, grant watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

- clock  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester read request, level
- lock  in  NUM_REQ  per-requester hold-grant request
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- gnt  out  NUM_REQ  one-hot grant, registered
- rvalid  out  NUM_REQ  one-hot read-data-valid pulse
- rdata  out  DATA_W  read data, mem_rdata passed through
- mem_addr  out  ADDR_W  memory address
- mem_rd  out  1  memory read strobe
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_rd
- busy  out  1  high while any grant or in-flight read exists
- timeout  out  1  one-cycle pulse on watchdog revoke (present only with ARB_TIMEOUT_EN)

## Operation
- FSM states: IDLE, GRANT.
- IDLE: if req != 0, winner = first set bit searching upward (with wrap) from last_winner+1; next cycle gnt = onehot(winner), last_winner <= winner, state GRANT. If req == 0, stay; gnt = 0.
- GRANT (owner o): mem_rd = req[o] & gnt[o]; mem_addr = req_addr[o] (combinational mux on registered owner). Each issued read pushes onehot(o) into an RD_LAT-deep tag shift register; rvalid = tag at depth RD_LAT.
- Release: at end of any GRANT cycle with lock[o] == 0, gnt <= 0, state IDLE (one bubble cycle before re-arbitration). With lock[o] == 1 the grant persists, even if req[o] is low (no mem_rd issued).
- Requests without lock receive exactly one access per grant.
- mem_addr = 0 and mem_rd = 0 whenever there is no grant.
- In-flight reads complete after release; rvalid goes to the original owner, not the current one.
- busy = (state == GRANT) | (tag pipeline != 0).
- Reset (including mid-scan): state IDLE, gnt = 0, last_winner = NUM_REQ-1 (so requester 0 wins first), tag pipeline cleared (pending rvalids dropped), rvalid = 0, mem_rd = 0, mem_addr = 0, busy = 0, timeout = 0.

## Timing
- req[i] rises in cycle 0 (IDLE): gnt[i] = 1 in cycle 1; mem_rd in cycle 1; rvalid[i] and rdata in cycle 1+RD_LAT.
- Locked scan: one read per cycle, back-to-back, addresses taken in the same cycle as mem_rd.
- Release after the cycle-n access: gnt = 0 in n+1 (IDLE), next gnt in n+2.
- Simultaneous requests: the round-robin pointer guarantees each requester waits at most NUM_REQ-1 grants.
- req and lock from non-owners are ignored during GRANT.

## Configuration
- ARB_TIMEOUT_EN defined: a hold counter resets on each grant and increments each GRANT cycle. When it reaches MAX_HOLD, the grant is forcibly released as if lock were low, and timeout pulses for one cycle.
- ARB_TIMEOUT_EN undefined: no counter and no timeout port; lock holds indefinitely.

## Structure
- Shared package (mem_pkg): ADDR_W/DATA_W defaults, table base addresses (QVALUE_BASE = 16'h01C8, QVALUE_LAST = 16'h0246, HCM_BASE = 16'h0648), arbiter state enum.
- One sub-module: rr_pick (combinational round-robin priority picker: req vector plus last winner in, one-hot plus index out).

## Test plan
- Single requester 1, RD_LAT=1, unlocked read of 16'h01C8 -> gnt[1] in cycle 1, mem_rd with addr 16'h01C8 in cycle 1, rvalid[1] with data in cycle 2, IDLE in cycle 2.
- Requester 0 locked scan from 16'h01C8 to 16'h0246 step 2 -> 64 consecutive mem_rd cycles, 64 rvalid[0] pulses in order, no gnt change.
- All four req high, unlocked -> grant order 0,1,2,3,0 with one bubble between grants.
- RD_LAT=3, owner 2 releases while reads are in flight and requester 3 is granted -> the trailing rvalids go to bit 2 only.
- rst asserted mid-scan with two reads in flight -> next cycle all outputs 0, no rvalid afterwards, and requester 0 wins the following arbitration.
- ARB_TIMEOUT_EN, MAX_HOLD=8, lock held forever -> grant revoked after 8 GRANT cycles, timeout pulses once, and the waiting requester is granted two cycles later.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the node-memory read-port arbiter: default widths,
// table base addresses and the arbiter state encoding.
package mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  localparam logic [15:0] QVALUE_BASE = 16'h01C8;
  localparam logic [15:0] QVALUE_LAST = 16'h0246;
  localparam logic [15:0] HCM_BASE    = 16'h0648;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward,
// with wrap, from the position just after the previous winner.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // NOTE: every output gets a default before the search loop, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!valid_o && req_i[(int'(last_i) + k) % NUM_REQ]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'((int'(last_i) + k) % NUM_REQ);
        onehot_o[(int'(last_i) + k) % NUM_REQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the node memory read port with grant lock and
// owner-tagged read returns. Optional grant watchdog: ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 256
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_rd,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                      timeout
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   last_q, last_d;   // also the current owner while in GRANT
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               expire;
  logic [NUM_REQ-1:0] tag_q [RD_LAT];
  logic               tag_any;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = pick_onehot;
          last_d  = pick_idx;
        end
      end
      GRANT: begin
        if (!lock[last_q] || expire) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  assign mem_rd   = (state_q == GRANT) && req[last_q] && gnt_q[last_q];
  assign mem_addr = (state_q == GRANT) ? req_addr[last_q*ADDR_W +: ADDR_W] : '0;

  // NOTE: the tag pipe is reset on purpose so reads in flight across a reset
  // never raise rvalid; a plain data pipeline would be left unreset.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= mem_rd ? gnt_q : '0;
      for (int k = 1; k < RD_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  always_comb begin
    tag_any = 1'b0;
    for (int k = 0; k < RD_LAT; k++) tag_any = tag_any | (|tag_q[k]);
  end

  assign gnt    = gnt_q;
  assign rvalid = tag_q[RD_LAT-1];
  assign rdata  = mem_rdata;
  assign busy   = (state_q == GRANT) || tag_any;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] hold_q, hold_d;
  logic             timeout_q;

  // Counter restarts on every new grant; expiry forces the release path.
  assign hold_d = (state_q == IDLE) ? '0 : hold_q + 1'b1;
  assign expire = (state_q == GRANT) && (hold_q == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clock) begin
    if (rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= expire;
    end
  end

  assign timeout = timeout_q;
`else
  localparam int unused_max_hold = MAX_HOLD;
  assign expire = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: two instances (RD_LAT 1 and 3) share
// stimulus; expected read returns are queued when requests are driven.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic [3:0]  req   = '0;
  logic [3:0]  lock  = '0;
  logic [63:0] req_addr = '0;

  logic [3:0]  gnt1, rvalid1, gnt3, rvalid3;
  logic [15:0] rdata1, mem_addr1, mem_rdata1, rdata3, mem_addr3, mem_rdata3;
  logic        mem_rd1, busy1, mem_rd3, busy3;
`ifdef ARB_TIMEOUT_EN
  logic        timeout1, timeout3;
`endif

  always #5 clock = ~clock;

  mem_port_arbiter #(.NUM_REQ(4), .RD_LAT(1), .MAX_HOLD(8)) dut1 (
    .clock(clock), .rst(rst), .req(req), .lock(lock), .req_addr(req_addr),
    .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1), .mem_addr(mem_addr1),
    .mem_rd(mem_rd1), .mem_rdata(mem_rdata1), .busy(busy1)
`ifdef ARB_TIMEOUT_EN
    , .timeout(timeout1)
`endif
  );

  mem_port_arbiter #(.NUM_REQ(4), .RD_LAT(3)) dut3 (
    .clock(clock), .rst(rst), .req(req), .lock(lock), .req_addr(req_addr),
    .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .mem_addr(mem_addr3),
    .mem_rd(mem_rd3), .mem_rdata(mem_rdata3), .busy(busy3)
`ifdef ARB_TIMEOUT_EN
    , .timeout(timeout3)
`endif
  );

  typedef struct packed {
    logic [3:0]  tag;
    logic [15:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  // Memory models with 1- and 3-cycle read latency.
  logic [15:0] pipe1;
  logic [15:0] pipe3 [3];
  always @(posedge clock) begin
    pipe1    <= mem_rd1 ? mem_word(mem_addr1) : 16'hDEAD;
    pipe3[0] <= mem_rd3 ? mem_word(mem_addr3) : 16'hDEAD;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_rdata1 = pipe1;
  assign mem_rdata3 = pipe3[2];

  // Read-return monitor: every rvalid must match the head of its queue.
  always @(negedge clock) begin
    if (rvalid1 !== 4'b0000) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL rvalid1_unexpected got tag %b data %h expected no return", rvalid1, rdata1);
      end else begin
        e1 = q1.pop_front();
        if ({rvalid1, rdata1} !== {e1.tag, e1.data}) begin
          errors++;
          $display("FAIL rvalid1_return got tag %b data %h expected tag %b data %h",
                   rvalid1, rdata1, e1.tag, e1.data);
        end
      end
    end
    if (rvalid3 !== 4'b0000) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL rvalid3_unexpected got tag %b data %h expected no return", rvalid3, rdata3);
      end else begin
        e3 = q3.pop_front();
        if ({rvalid3, rdata3} !== {e3.tag, e3.data}) begin
          errors++;
          $display("FAIL rvalid3_return got tag %b data %h expected tag %b data %h",
                   rvalid3, rdata3, e3.tag, e3.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic set_addr(input int i, input logic [15:0] a);
    req_addr[i*16 +: 16] = a;
  endtask

  task automatic push_both(input logic [3:0] tag, input logic [15:0] a);
    q1.push_back({tag, mem_word(a)});
    q3.push_back({tag, mem_word(a)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    lock = '0;
    req_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    q1.delete();
    q3.delete();
  endtask

  task automatic drain_check(input string name);
    repeat (6) tick();
    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got pending %0d/%0d expected 0/0", name, q1.size(), q3.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    sample();
    checks++;
    if ({gnt1, rvalid1, mem_rd1, mem_addr1, busy1} !== '0) begin
      errors++;
      $display("FAIL reset_dut1 got gnt %b rvalid %b rd %b addr %h busy %b expected all 0",
               gnt1, rvalid1, mem_rd1, mem_addr1, busy1);
    end
    checks++;
    if ({gnt3, rvalid3, mem_rd3, mem_addr3, busy3} !== '0) begin
      errors++;
      $display("FAIL reset_dut3 got gnt %b rvalid %b rd %b addr %h busy %b expected all 0",
               gnt3, rvalid3, mem_rd3, mem_addr3, busy3);
    end
`ifdef ARB_TIMEOUT_EN
    checks++;
    if (timeout1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_timeout got %b expected 0", timeout1);
    end
`endif
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0010;
    set_addr(1, QVALUE_BASE);
    push_both(4'b0010, QVALUE_BASE);
    sample();
    checks++;
    if (gnt1 !== 4'b0000) begin
      errors++;
      $display("FAIL single_c0_gnt got %b expected 0000", gnt1);
    end
    tick();
    sample();
    checks++;
    if ({gnt1, mem_rd1, mem_addr1, busy1} !== {4'b0010, 1'b1, QVALUE_BASE, 1'b1}) begin
      errors++;
      $display("FAIL single_c1 got gnt %b rd %b addr %h busy %b expected 0010 1 01c8 1",
               gnt1, mem_rd1, mem_addr1, busy1);
    end
    tick();
    req = 4'b0000;
    sample();
    checks++;
    if ({gnt1, mem_rd1, rvalid1, rdata1} !== {4'b0000, 1'b0, 4'b0010, mem_word(QVALUE_BASE)}) begin
      errors++;
      $display("FAIL single_c2 got gnt %b rd %b rvalid %b data %h expected 0000 0 0010 %h",
               gnt1, mem_rd1, rvalid1, rdata1, mem_word(QVALUE_BASE));
    end
    tick();
    sample();
    checks++;
    if ({busy1, rvalid1} !== 5'b0) begin
      errors++;
      $display("FAIL single_c3 got busy %b rvalid %b expected 0 0000", busy1, rvalid1);
    end
    drain_check("single");
  endtask

  task automatic test_locked_scan();
    logic [15:0] a;
    do_reset();
    req  = 4'b0001;
    lock = 4'b0001;
    set_addr(0, QVALUE_BASE);
    for (int k = 0; k < 64; k++) begin
      tick();
      a = QVALUE_BASE + 16'(2 * k);
      set_addr(0, a);
      push_both(4'b0001, a);
      sample();
      checks++;
      if ({gnt1, mem_rd1, mem_addr1} !== {4'b0001, 1'b1, a}) begin
        errors++;
        $display("FAIL scan1_k%0d got gnt %b rd %b addr %h expected 0001 1 %h",
                 k, gnt1, mem_rd1, mem_addr1, a);
      end
      checks++;
      if ({gnt3, mem_rd3, mem_addr3} !== {4'b0001, 1'b1, a}) begin
        errors++;
        $display("FAIL scan3_k%0d got gnt %b rd %b addr %h expected 0001 1 %h",
                 k, gnt3, mem_rd3, mem_addr3, a);
      end
    end
    checks++;
    if (mem_addr1 !== QVALUE_LAST) begin
      errors++;
      $display("FAIL scan_last_addr got %h expected %h", mem_addr1, QVALUE_LAST);
    end
    tick();
    req  = 4'b0000;
    lock = 4'b0000;
    sample();
    checks++;
    if ({gnt1, mem_rd1} !== {4'b0001, 1'b0}) begin
      errors++;
      $display("FAIL scan_hold_idle got gnt %b rd %b expected 0001 0", gnt1, mem_rd1);
    end
    tick();
    sample();
    checks++;
    if (gnt1 !== 4'b0000) begin
      errors++;
      $display("FAIL scan_release got gnt %b expected 0000", gnt1);
    end
    drain_check("scan");
  endtask

  task automatic test_round_robin();
    logic [3:0]  oh;
    logic [15:0] a;
    do_reset();
    for (int i = 0; i < 4; i++) set_addr(i, HCM_BASE + 16'(2 * i));
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      oh = 4'b0001 << (g % 4);
      a  = HCM_BASE + 16'(2 * (g % 4));
      push_both(oh, a);
      sample();
      checks++;
      if ({gnt1, mem_rd1, mem_addr1} !== {oh, 1'b1, a}) begin
        errors++;
        $display("FAIL rr_grant%0d got gnt %b rd %b addr %h expected %b 1 %h",
                 g, gnt1, mem_rd1, mem_addr1, oh, a);
      end
      tick();
      if (g == 4) req = 4'b0000;
      sample();
      checks++;
      if ({gnt1, mem_rd1} !== 5'b0) begin
        errors++;
        $display("FAIL rr_bubble%0d got gnt %b rd %b expected 0000 0", g, gnt1, mem_rd1);
      end
    end
    drain_check("rr");
  endtask

  task automatic test_inflight();
    do_reset();
    req  = 4'b1100;
    lock = 4'b0100;
    set_addr(2, QVALUE_BASE + 16'h10);
    set_addr(3, HCM_BASE);
    tick();
    push_both(4'b0100, QVALUE_BASE + 16'h10);
    sample();
    checks++;
    if (gnt3 !== 4'b0100) begin
      errors++;
      $display("FAIL inflight_gnt2 got %b expected 0100", gnt3);
    end
    tick();
    set_addr(2, QVALUE_BASE + 16'h12);
    push_both(4'b0100, QVALUE_BASE + 16'h12);
    tick();
    set_addr(2, QVALUE_BASE + 16'h14);
    lock = 4'b0000;
    push_both(4'b0100, QVALUE_BASE + 16'h14);
    tick();
    req = 4'b1000;
    sample();
    checks++;
    if ({gnt3, rvalid3} !== {4'b0000, 4'b0100}) begin
      errors++;
      $display("FAIL inflight_c4 got gnt %b rvalid %b expected 0000 0100", gnt3, rvalid3);
    end
    tick();
    push_both(4'b1000, HCM_BASE);
    sample();
    checks++;
    if ({gnt3, rvalid3} !== {4'b1000, 4'b0100}) begin
      errors++;
      $display("FAIL inflight_c5 got gnt %b rvalid %b expected 1000 0100", gnt3, rvalid3);
    end
    tick();
    req = 4'b0000;
    sample();
    checks++;
    if (rvalid3 !== 4'b0100) begin
      errors++;
      $display("FAIL inflight_c6 got rvalid %b expected 0100", rvalid3);
    end
    drain_check("inflight");
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    req  = 4'b0100;
    lock = 4'b0100;
    set_addr(2, QVALUE_BASE);
    tick();
    q1.push_back({4'b0100, mem_word(QVALUE_BASE)});
    tick();
    set_addr(2, QVALUE_BASE + 16'h2);
    rst = 1'b1;
    sample();
    checks++;
    if (busy3 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy got %b expected 1", busy3);
    end
    tick();
    rst  = 1'b0;
    req  = 4'b1101;
    lock = 4'b0000;
    set_addr(0, HCM_BASE + 16'h8);
    set_addr(3, HCM_BASE + 16'h6);
    sample();
    checks++;
    if ({gnt1, rvalid1, mem_rd1, mem_addr1, busy1, gnt3, rvalid3, mem_rd3, mem_addr3, busy3} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got gnt %b/%b rvalid %b/%b rd %b/%b busy %b/%b expected all 0",
               gnt1, gnt3, rvalid1, rvalid3, mem_rd1, mem_rd3, busy1, busy3);
    end
    tick();
    push_both(4'b0001, HCM_BASE + 16'h8);
    sample();
    checks++;
    if ({gnt1, gnt3} !== {4'b0001, 4'b0001}) begin
      errors++;
      $display("FAIL midrst_rearb got gnt %b/%b expected 0001/0001", gnt1, gnt3);
    end
    tick();
    req = 4'b0000;
    drain_check("midrst");
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req  = 4'b0011;
    lock = 4'b0001;
    set_addr(1, HCM_BASE + 16'h20);
    for (int k = 1; k <= 8; k++) begin
      tick();
      req = 4'b0010;
      sample();
      checks++;
      if ({gnt1, timeout1} !== {4'b0001, 1'b0}) begin
        errors++;
        $display("FAIL tmo_hold%0d got gnt %b timeout %b expected 0001 0", k, gnt1, timeout1);
      end
    end
    tick();
    sample();
    checks++;
    if ({gnt1, timeout1} !== {4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL tmo_revoke got gnt %b timeout %b expected 0000 1", gnt1, timeout1);
    end
    tick();
    q1.push_back({4'b0010, mem_word(HCM_BASE + 16'h20)});
    sample();
    checks++;
    if ({gnt1, timeout1, mem_rd1} !== {4'b0010, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL tmo_next got gnt %b timeout %b rd %b expected 0010 0 1", gnt1, timeout1, mem_rd1);
    end
    tick();
    req  = 4'b0000;
    lock = 4'b0000;
    drain_check("tmo");
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_locked_scan();
    test_round_robin();
    test_inflight();
    test_reset_mid_scan();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion expected finish within 200000");
    $fatal(1);
  end

endmodule
